// File: rtl/data_cache_if.sv
// data_cache_if: CPU data port and word-serial backing-memory bus of the data cache
// Ports (slave = cache side):
//   rd_req, wr_en, addr, wr_data     CPU request (held stable while miss=1)
//   rd_data, miss                    load data and stall request to the hazard unit
//   mem_rd_req, mem_wr_req, mem_addr, mem_wr_data   beat request towards memory
//   mem_rd_data, mem_ready           refill data and beat accept/valid from memory
interface data_cache_if #(parameter int ADDR_W = 32);
  logic              rd_req;
  logic [3:0]        wr_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_data;
  logic              miss;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic [31:0]       mem_rd_data;
  logic              mem_ready;
  modport slave (
    input  rd_req, wr_en, addr, wr_data, mem_rd_data, mem_ready,
    output rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
  );
  modport master (
    output rd_req, wr_en, addr, wr_data, mem_rd_data, mem_ready,
    input  rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: write-back, write-allocate data cache (1 or 2 ways, LRU) with word-serial refill/writeback
// Ports: clk; rst (asynchronous, active low); bus (data_cache_if.slave, CPU + memory side);
//   hit_cnt/miss_cnt saturating statistics only when DCACHE_STATS_EN is defined.
module data_cache #(
  parameter int ADDR_W   = 32,
  parameter int SET_LOG  = 4,
  parameter int LINE_LOG = 2,
  parameter int WAYS     = 2
) (
  input logic clk,
  input logic rst,
  data_cache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int SETS  = 1 << SET_LOG;
  localparam int WORDS = 1 << LINE_LOG;
  localparam int TAG_W = ADDR_W - SET_LOG - LINE_LOG - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESUME} state_t;
  state_t state, nextState;
  // Storage is always declared for two ways; with WAYS=1 way 1 is never hit, chosen or written.
  logic [31:0] lineData [2][SETS][WORDS];
  logic [TAG_W-1:0] tagMem [2][SETS];
  logic [SETS-1:0] valid [2];
  logic [SETS-1:0] dirty [2];
  logic [SETS-1:0] lru;
  logic [LINE_LOG-1:0] beat, word;
  logic [SET_LOG-1:0] idx, missIdx;
  logic [TAG_W-1:0] reqTag, missTag;
  logic victim, victimSel, hitWay, hit, wayHit0, wayHit1, request, missStart, lastBeat, beatDone;
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.addr[1:0];
  assign word = bus.addr[LINE_LOG+1:2];
  assign idx = bus.addr[LINE_LOG+2 +: SET_LOG];
  assign reqTag = bus.addr[ADDR_W-1 -: TAG_W];
  assign request = bus.rd_req | (|bus.wr_en);
  assign wayHit0 = valid[0][idx] && tagMem[0][idx] == reqTag;
  assign wayHit1 = (WAYS == 2) && valid[1][idx] && tagMem[1][idx] == reqTag;
  assign hitWay = wayHit1;
  assign hit = state == IDLE && request && (wayHit0 || wayHit1);
  // Held in reset, no miss is raised even if the CPU keeps its request up.
  assign missStart = rst && state == IDLE && request && !hit;
  assign victimSel = (WAYS == 1) ? 1'b0 : !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign lastBeat = &beat;
  assign beatDone = (state == WRITEBACK || state == REFILL) && bus.mem_ready;
  always_comb begin
    nextState = state == IDLE ? (missStart ? ((valid[victimSel][idx] && dirty[victimSel][idx]) ? WRITEBACK : REFILL) : IDLE)
              : state == WRITEBACK ? ((bus.mem_ready && lastBeat) ? REFILL : WRITEBACK)
              : state == REFILL ? ((bus.mem_ready && lastBeat) ? RESUME : REFILL)
              : IDLE;
    bus.miss = state != IDLE || missStart;
    bus.rd_data = hit ? lineData[hitWay][idx][word] : '0;
    bus.mem_wr_req = state == WRITEBACK;
    bus.mem_rd_req = state == REFILL;
    bus.mem_addr = state == WRITEBACK ? {tagMem[victim][missIdx], missIdx, beat, 2'b00}
                 : state == REFILL ? {missTag, missIdx, beat, 2'b00} : '0;
    bus.mem_wr_data = state == WRITEBACK ? lineData[victim][missIdx][beat] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat <= '0;
      valid <= '{default: '0};
      dirty <= '{default: '0};
      lru <= '0;
      victim <= 1'b0;
      missIdx <= '0;
      missTag <= '0;
    end else begin
      state <= nextState;
      // Counter restarts on every state change, which also covers the wrap after the last beat.
      beat <= nextState != state ? '0 : beatDone ? beat + 1'b1 : beat;
      if (missStart) begin
        victim <= victimSel;
        missIdx <= idx;
        missTag <= reqTag;
      end
      if (hit) lru[idx] <= ~hitWay;
      if (hit && |bus.wr_en) dirty[hitWay][idx] <= 1'b1;
      if (state == WRITEBACK && bus.mem_ready && lastBeat) dirty[victim][missIdx] <= 1'b0;
      if (state == REFILL && bus.mem_ready && lastBeat) begin
        valid[victim][missIdx] <= 1'b1;
        dirty[victim][missIdx] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (hit && bus.wr_en[b]) lineData[hitWay][idx][word][8*b +: 8] <= bus.wr_data[8*b +: 8];
    if (state == REFILL && bus.mem_ready) lineData[victim][missIdx][beat] <= bus.mem_rd_data;
    if (state == REFILL && bus.mem_ready && lastBeat) tagMem[victim][missIdx] <= missTag;
  end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (missStart && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed vector bench for data_cache with a word-addressed backing memory model
module tb_data_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit memReady;
  bit toggleReady;
  data_cache_if #(.ADDR_W(32)) bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] hitCnt, missCnt;
`endif
  data_cache #(.ADDR_W(32), .SET_LOG(4), .LINE_LOG(2), .WAYS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt(hitCnt),
    .miss_cnt(missCnt)
`endif
  );
  always #5 clk = ~clk;
  // Memory: an unwritten word reads back as its own byte address.
  bit memValid [1024];
  logic [31:0] memArr [1024];
  assign bus.mem_rd_data = memValid[bus.mem_addr[11:2]] ? memArr[bus.mem_addr[11:2]] : bus.mem_addr;
  assign bus.mem_ready = memReady;
  always @(posedge clk) begin
    #1;
    memReady = toggleReady ? ~memReady : 1'b1;
  end
  typedef struct { bit w; logic [31:0] a; logic [31:0] d; } beat_t;
  beat_t beats[$];
  int holdBad, holdSeen;
  bit holdPending;
  logic [31:0] holdAddr;
  always @(negedge clk) begin
    if (holdPending && bus.mem_rd_req) begin
      holdSeen++;
      if (bus.mem_addr != holdAddr) holdBad++;
    end
    holdPending = bus.mem_rd_req && !memReady;
    holdAddr = bus.mem_addr;
    if (bus.mem_rd_req && memReady) beats.push_back('{1'b0, bus.mem_addr, bus.mem_rd_data});
    if (bus.mem_wr_req && memReady) begin
      beats.push_back('{1'b1, bus.mem_addr, bus.mem_wr_data});
      memArr[bus.mem_addr[11:2]] = bus.mem_wr_data;
      memValid[bus.mem_addr[11:2]] = 1'b1;
    end
  end
  int nChk, nErr;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic access(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output int stall);
    @(negedge clk);
    bus.rd_req = r;
    bus.wr_en = w;
    bus.addr = a;
    bus.wr_data = wd;
    #1;
    stall = 0;
    while (bus.miss && stall < 200) begin
      @(negedge clk);
      stall++;
    end
    rdat = bus.rd_data;
    @(posedge clk);
    #1;
    bus.rd_req = 1'b0;
    bus.wr_en = 4'h0;
  endtask
  typedef struct {
    logic rd; logic [3:0] we; logic [31:0] a; logic [31:0] wd; logic [31:0] expData;
    int expStall; int expWr; int expRd; logic [31:0] wrBase;
  } vec_t;
  vec_t vecs[16];
  initial begin
    logic [31:0] d, rdBase;
    int s, start, nW, nR, waitCnt;
    bit addrOk;
    bus.rd_req = 1'b0;
    bus.wr_en = 4'h0;
    bus.addr = '0;
    bus.wr_data = '0;
    vecs[0]  = '{1'b1, 4'h0, 32'h100, 32'h0,        32'h100,      6,  0, 4, 32'h0};
    vecs[1]  = '{1'b0, 4'h2, 32'h104, 32'h0000AB00, 32'h0,        0,  0, 0, 32'h0};
    vecs[2]  = '{1'b1, 4'h0, 32'h104, 32'h0,        32'h0000AB04, 0,  0, 0, 32'h0};
    vecs[3]  = '{1'b1, 4'h0, 32'h500, 32'h0,        32'h500,      6,  0, 4, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h900, 32'h0,        32'h900,      10, 4, 4, 32'h100};
    vecs[5]  = '{1'b1, 4'h0, 32'h104, 32'h0,        32'h0000AB04, 6,  0, 4, 32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h500, 32'h0,        32'h500,      6,  0, 4, 32'h0};
    vecs[7]  = '{1'b1, 4'h0, 32'h100, 32'h0,        32'h100,      0,  0, 0, 32'h0};
    vecs[8]  = '{1'b1, 4'h0, 32'h900, 32'h0,        32'h900,      6,  0, 4, 32'h0};
    vecs[9]  = '{1'b1, 4'h0, 32'h100, 32'h0,        32'h100,      0,  0, 0, 32'h0};
    vecs[10] = '{1'b1, 4'h0, 32'h500, 32'h0,        32'h500,      6,  0, 4, 32'h0};
    vecs[11] = '{1'b1, 4'hF, 32'h210, 32'hDEADBEEF, 32'h0,        6,  0, 4, 32'h0};
    vecs[12] = '{1'b1, 4'h0, 32'h210, 32'h0,        32'hDEADBEEF, 0,  0, 0, 32'h0};
    vecs[13] = '{1'b0, 4'h8, 32'h218, 32'h12000000, 32'h0,        0,  0, 0, 32'h0};
    vecs[14] = '{1'b1, 4'h0, 32'h218, 32'h0,        32'h12000218, 0,  0, 0, 32'h0};
    vecs[15] = '{1'b1, 4'h0, 32'h214, 32'h0,        32'h214,      0,  0, 0, 32'h0};
    #12;
    chk("reset_miss", 32'(bus.miss), 32'd0);
    chk("reset_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
    chk("reset_mem_wr_req", 32'(bus.mem_wr_req), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    chk("reset_rd_data", bus.rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      start = beats.size();
      access(vecs[i].rd, vecs[i].we, vecs[i].a, vecs[i].wd, d, s);
      chk($sformatf("v%0d_stall", i), 32'(s), 32'(vecs[i].expStall));
      if (vecs[i].rd && vecs[i].we == 4'h0) chk($sformatf("v%0d_rd_data", i), d, vecs[i].expData);
      rdBase = vecs[i].a & ~32'hF;
      nW = 0;
      nR = 0;
      addrOk = 1'b1;
      for (int j = start; j < beats.size(); j++) begin
        if (beats[j].w) begin
          if (nR > 0 || beats[j].a != vecs[i].wrBase + 32'(4 * nW)) addrOk = 1'b0;
          nW++;
        end else begin
          if (beats[j].a != rdBase + 32'(4 * nR)) addrOk = 1'b0;
          nR++;
        end
      end
      chk($sformatf("v%0d_wr_beats", i), 32'(nW), 32'(vecs[i].expWr));
      chk($sformatf("v%0d_rd_beats", i), 32'(nR), 32'(vecs[i].expRd));
      chk($sformatf("v%0d_beat_addr", i), 32'(addrOk), 32'd1);
      if (nW > 1) chk($sformatf("v%0d_wb_word1", i), beats[start+1].d, 32'h0000AB04);
    end
    // Backpressure: ready toggles every cycle through the refill.
    toggleReady = 1'b1;
    start = beats.size();
    access(1'b1, 4'h0, 32'h338, 32'h0, d, s);
    toggleReady = 1'b0;
    chk("bp_rd_data", d, 32'h338);
    chk("bp_rd_beats", 32'(beats.size() - start), 32'd4);
    addrOk = 1'b1;
    for (int j = start; j < beats.size(); j++)
      if (beats[j].w || beats[j].a != 32'h330 + 32'(4 * (j - start))) addrOk = 1'b0;
    chk("bp_beat_addr", 32'(addrOk), 32'd1);
    chk("bp_hold_seen", 32'(holdSeen > 0), 32'd1);
    chk("bp_hold_addr", 32'(holdBad), 32'd0);
    // Reset during the third refill beat.
    start = beats.size();
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.addr = 32'h440;
    waitCnt = 0;
    #1;
    while (beats.size() - start < 3 && waitCnt < 50) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    chk("rst_reach_beat2", 32'(beats.size() - start >= 3), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_miss", 32'(bus.miss), 32'd0);
    chk("rst_mid_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    rst = 1'b1;
    access(1'b1, 4'h0, 32'h440, 32'h0, d, s);
    chk("post_rst_stall", 32'(s), 32'd6);
    chk("post_rst_rd_data", d, 32'h440);
    access(1'b1, 4'h0, 32'h100, 32'h0, d, s);
    chk("post_rst_old_line_stall", 32'(s), 32'd6);
    $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
    $finish;
  end
endmodule
